// File: rtl/risc_spm_pkg.sv
// Shared constants and types for the RISC-SPM memory subsystem: bus widths,
// burst limit, arbiter state encoding and port-select values.
package risc_spm_pkg;

  localparam int DEF_WORD_SIZE = 8;
  localparam int DEF_ADDR_SIZE = 8;
  localparam int DEF_MAX_BURST = 4;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_GRANT_A = 2'd2,
    ST_GRANT_B = 2'd3
  } arb_state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory. Port B (the
// loader) owns memory during boot; afterwards CPU port A and port B share it.
module mem_arbiter
  import risc_spm_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_a,
  input  logic                 we_a,
  input  logic [ADDR_SIZE-1:0] addr_a,
  input  logic [WORD_SIZE-1:0] wdata_a,
  output logic                 gnt_a,
  output logic [WORD_SIZE-1:0] rdata_a,
  output logic                 rvalid_a,
  input  logic                 req_b,
  input  logic                 we_b,
  input  logic [ADDR_SIZE-1:0] addr_b,
  input  logic [WORD_SIZE-1:0] wdata_b,
  output logic                 gnt_b,
  output logic [WORD_SIZE-1:0] rdata_b,
  output logic                 rvalid_b,
  input  logic                 boot_done,
  output logic                 cpu_run,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       r_state;
  arb_state_t       w_state_next;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  port_sel_t        r_last_served;
  port_sel_t        w_last_next;
  logic             r_rvalid_a;
  logic             r_rvalid_b;
  logic             w_beat_a;
  logic             w_beat_b;
  logic             w_burst_end;

  // A beat never happens in a reset cycle, which also aborts any read in flight.
  assign w_beat_a    = !rst && (r_state == ST_GRANT_A) && req_a;
  assign w_beat_b    = !rst && ((r_state == ST_GRANT_B) || (r_state == ST_BOOT)) && req_b;
  assign w_burst_end = (r_beat_cnt == CNT_W'(MAX_BURST - 1));

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      r_state       <= ST_BOOT;
      r_beat_cnt    <= '0;
      r_last_served <= PORT_A;
      r_rvalid_a    <= 1'b0;
      r_rvalid_b    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_beat_cnt    <= w_cnt_next;
      r_last_served <= w_last_next;
      r_rvalid_a    <= w_beat_a && !we_a;
      r_rvalid_b    <= w_beat_b && !we_b;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    w_state_next = r_state;
    w_cnt_next   = r_beat_cnt;
    w_last_next  = r_last_served;
    unique case (r_state)
      ST_BOOT: begin
        if (boot_done) w_state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (req_a && req_b)
          w_state_next = (r_last_served == PORT_A) ? ST_GRANT_B : ST_GRANT_A;
        else if (req_a)
          w_state_next = ST_GRANT_A;
        else if (req_b)
          w_state_next = ST_GRANT_B;
      end
      ST_GRANT_A: begin
        if (!req_a) begin
          w_state_next = req_b ? ST_GRANT_B : ST_IDLE;
        end else if (w_burst_end) begin
          w_cnt_next = '0;
          if (req_b) w_state_next = ST_GRANT_B;
        end else begin
          w_cnt_next = r_beat_cnt + 1'b1;
        end
      end
      ST_GRANT_B: begin
        if (!req_b) begin
          w_state_next = req_a ? ST_GRANT_A : ST_IDLE;
        end else if (w_burst_end) begin
          w_cnt_next = '0;
          if (req_a) w_state_next = ST_GRANT_A;
        end else begin
          w_cnt_next = r_beat_cnt + 1'b1;
        end
      end
      default: w_state_next = ST_BOOT;
    endcase
    // Any state change restarts the burst count and records who was just served.
    if (w_state_next != r_state) begin
      w_cnt_next = '0;
      if (r_state == ST_GRANT_A) w_last_next = PORT_A;
      if (r_state == ST_GRANT_B) w_last_next = PORT_B;
    end
  end

  // Output logic
  always_comb begin
    gnt_a     = w_beat_a;
    gnt_b     = w_beat_b;
    mem_en    = w_beat_a || w_beat_b;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_beat_a) begin
      mem_we    = we_a;
      mem_addr  = addr_a;
      mem_wdata = wdata_a;
    end else if (w_beat_b) begin
      mem_we    = we_b;
      mem_addr  = addr_b;
      mem_wdata = wdata_b;
    end
    // Read data arrives from memory the cycle after the beat; pass it straight through.
    rvalid_a = r_rvalid_a && !rst;
    rvalid_b = r_rvalid_b && !rst;
    rdata_a  = rvalid_a ? mem_rdata : '0;
    rdata_b  = rvalid_b ? mem_rdata : '0;
    cpu_run  = !rst && (r_state != ST_BOOT);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter: a bus-ownership reference
// model and a shadow memory predict every grant, memory command and read return.
module tb_mem_arbiter;

  localparam int MAX_BURST = 4;

  logic       clk = 1'b0;
  logic       rst, boot_done;
  logic       req_a, we_a, gnt_a, rvalid_a;
  logic [7:0] addr_a, wdata_a, rdata_a;
  logic       req_b, we_b, gnt_b, rvalid_b;
  logic [7:0] addr_b, wdata_b, rdata_b;
  logic       cpu_run, mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;

  always #5 clk = ~clk;

  mem_arbiter #(.WORD_SIZE(8), .ADDR_SIZE(8), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b),
    .boot_done(boot_done), .cpu_run(cpu_run),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // External synchronous memory driven by the DUT.
  logic [7:0] ram [256] = '{default: 8'h00};
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requesters: index 0 = port A, 1 = port B. A port requests while beats remain.
  int         p_left [2];
  logic       p_we   [2];
  logic [7:0] p_addr [2];
  logic [7:0] p_data [2];
  bit         rnd_mode = 0;
  bit         rst_r = 0;
  bit         bd_r = 0;

  // Reference model: who owns the bus, how long it has held it, who went last.
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  bit         m_booted;
  int         m_owner;      // 0 nobody, 1 A, 2 B
  int         m_run;
  int         m_last;       // 1 A, 2 B
  bit         m_pend [2];
  logic [7:0] m_pend_d [2];

  // Observations of the last step, used by the directed scenarios.
  bit         o_ga, o_gb, o_rva, o_run;
  logic [7:0] o_rda;

  task automatic step();
    bit         eg [2];
    bit         req [2];
    bit         beat;
    int         bp;
    for (int i = 0; i < 2; i++) req[i] = (p_left[i] > 0);
    rst = rst_r; boot_done = bd_r;
    req_a = req[0]; we_a = p_we[0]; addr_a = p_addr[0]; wdata_a = p_data[0];
    req_b = req[1]; we_b = p_we[1]; addr_b = p_addr[1]; wdata_b = p_data[1];
    #2;
    eg[0] = 0; eg[1] = 0;
    if (!rst_r) begin
      if (!m_booted)         eg[1] = req[1];
      else if (m_owner == 1) eg[0] = req[0];
      else if (m_owner == 2) eg[1] = req[1];
    end
    beat = eg[0] || eg[1];
    bp   = eg[0] ? 0 : 1;
    check("gnt_a", gnt_a, eg[0]);
    check("gnt_b", gnt_b, eg[1]);
    check("no_overlap", gnt_a && gnt_b, 0);
    check("cpu_run", cpu_run, m_booted && !rst_r);
    check("mem_en", mem_en, beat);
    check("mem_we", mem_we, beat && p_we[bp]);
    if (beat) begin
      check("mem_addr", mem_addr, p_addr[bp]);
      check("mem_wdata", mem_wdata, p_data[bp]);
    end
    if (rst_r) begin
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_rdata", {rdata_a, rdata_b}, 0);
    end
    check("rvalid_a", rvalid_a, m_pend[0] && !rst_r);
    check("rvalid_b", rvalid_b, m_pend[1] && !rst_r);
    if (m_pend[0] && !rst_r) check("rdata_a", rdata_a, m_pend_d[0]);
    if (m_pend[1] && !rst_r) check("rdata_b", rdata_b, m_pend_d[1]);
    o_ga = gnt_a; o_gb = gnt_b; o_rva = rvalid_a; o_rda = rdata_a; o_run = cpu_run;

    // Advance the model to the next cycle.
    m_pend[0] = 0; m_pend[1] = 0;
    if (rst_r) begin
      m_booted = 0; m_owner = 0; m_run = 0; m_last = 1;
    end else begin
      if (beat) begin
        if (p_we[bp]) ref_mem[p_addr[bp]] = p_data[bp];
        else begin
          m_pend[bp]   = 1;
          m_pend_d[bp] = ref_mem[p_addr[bp]];
        end
      end
      if (!m_booted) begin
        if (bd_r) begin m_booted = 1; m_owner = 0; m_run = 0; end
      end else if (m_owner == 0) begin
        if (req[0] && req[1]) m_owner = (m_last == 1) ? 2 : 1;
        else if (req[0])      m_owner = 1;
        else if (req[1])      m_owner = 2;
        m_run = 0;
      end else begin
        int me    = m_owner - 1;
        int other = 1 - me;
        if (!req[me]) begin
          m_last  = m_owner;
          m_owner = req[other] ? other + 1 : 0;
          m_run   = 0;
        end else begin
          m_run++;
          if (m_run == MAX_BURST) begin
            m_run = 0;
            if (req[other]) begin m_last = m_owner; m_owner = other + 1; end
          end
        end
      end
    end

    // Requester bookkeeping: a granted beat consumes one request.
    for (int i = 0; i < 2; i++) begin
      if (eg[i]) begin
        p_left[i]--;
        p_addr[i] = p_addr[i] + 8'd1;
        p_data[i] = p_data[i] + 8'd3;
      end
      if (rnd_mode && p_left[i] == 0 && ($urandom % 2) == 0) begin
        p_left[i] = $urandom_range(1, 6);
        p_we[i]   = $urandom % 2;
        p_addr[i] = 8'($urandom % 16);
        p_data[i] = 8'($urandom);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic set_port(input int p, input int n, input logic we, input logic [7:0] a,
                          input logic [7:0] d);
    p_left[p] = n; p_we[p] = we; p_addr[p] = a; p_data[p] = d;
  endtask

  task automatic drain(input int max_cycles, input string tag);
    int n = 0;
    while ((p_left[0] > 0 || p_left[1] > 0) && n < max_cycles) begin
      step();
      n++;
    end
    check(tag, p_left[0] + p_left[1], 0);
  endtask

  task automatic do_reset();
    rst_r = 1; step(); rst_r = 0;
  endtask

  initial begin
    int lat, we_beats, gap, last_a, first_b, run_len, best;
    string seq;
    m_booted = 0; m_owner = 0; m_run = 0; m_last = 1;
    m_pend[0] = 0; m_pend[1] = 0; m_pend_d[0] = 0; m_pend_d[1] = 0;
    for (int i = 0; i < 2; i++) set_port(i, 0, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;
    do_reset();

    // Boot: loader writes while CPU waits with a pending read of 129.
    set_port(0, 1, 1'b0, 8'd129, 8'h00);
    we_beats = 0;
    set_port(1, 1, 1'b1, 8'h00, 8'h51); step(); we_beats += mem_we;
    set_port(1, 1, 1'b1, 8'h01, 8'h81); step(); we_beats += mem_we;
    check("boot_gnt_a", o_ga, 0);
    set_port(1, 1, 1'b1, 8'd129, 8'h02); step(); we_beats += mem_we;
    check("boot_we_beats", we_beats, 3);
    check("boot_cpu_run", o_run, 0);

    // Boot exit and the CPU's first read.
    bd_r = 1; step(); bd_r = 0;
    lat = 0;
    while (!o_ga && lat < 5) begin step(); lat++; end
    check("gnt_a_latency_ok", lat <= 2, 1);
    step();
    check("boot_read_rvalid", o_rva, 1);
    check("boot_read_rdata", o_rda, 8'h02);

    // Contention: both ports hold requests.
    set_port(0, 40, 1'b0, 8'h00, 8'h00);
    set_port(1, 40, 1'b0, 8'h80, 8'h00);
    seq = "";
    for (int i = 0; i < 24 && seq.len() < 16; i++) begin
      step();
      if (o_ga) seq = {seq, "A"};
      if (o_gb) seq = {seq, "B"};
    end
    check("contention_order", seq.substr(0, 15) == "BBBBAAAABBBBAAAA", 1);
    set_port(0, 0, 1'b0, 8'h00, 8'h00);
    set_port(1, 0, 1'b0, 8'h00, 8'h00);
    step(); step();

    // Early release: A takes two beats while B waits.
    set_port(0, 2, 1'b0, 8'h10, 8'h00);
    step();
    set_port(1, 2, 1'b0, 8'h20, 8'h00);
    last_a = -1; first_b = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_ga) last_a = i;
      if (o_gb && first_b < 0) first_b = i;
    end
    gap = first_b - last_a;
    check("early_release_gap", gap, 2);

    // Reset while a read of 130 is being granted.
    set_port(0, 5, 1'b0, 8'd130, 8'h00);
    lat = 0;
    while (!o_ga && lat < 8) begin step(); lat++; end
    check("pre_reset_gnt_a", o_ga, 1);
    do_reset();
    step();
    check("reset_rvalid_a", o_rva, 0);
    check("reset_cpu_run", o_run, 0);
    set_port(0, 0, 1'b0, 8'h00, 8'h00);

    // Solo burst: only A, ten beats, no gaps at burst boundaries.
    bd_r = 1; step(); bd_r = 0;
    set_port(0, 10, 1'b0, 8'h40, 8'h00);
    run_len = 0; best = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      run_len = o_ga ? run_len + 1 : 0;
      if (run_len > best) best = run_len;
    end
    check("solo_consecutive", best, 10);

    // Random traffic with occasional resets and boot_done pulses.
    rnd_mode = 1;
    for (int i = 0; i < 1500; i++) begin
      rst_r = ($urandom % 100) == 0;
      bd_r  = ($urandom % 8) == 0;
      step();
    end
    rst_r = 0; bd_r = 0; rnd_mode = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
